// File: rtl/pwm_gen_n_pkg.sv
// Shared definitions for the PWM generator: FSM state encoding and default sizing.
package pwm_pkg;

  localparam int PWM_WIDTH_DEF    = 8;
  localparam int PWM_CHANNELS_DEF = 4;

  typedef enum logic {
    IDLE,
    RUN
  } pwm_state_e;

  // Width of a channel index; a single channel still gets a 1-bit select.
  function automatic int ch_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pwm_gen_n_compare.sv
// Unsigned magnitude comparator used for the duty and wrap tests.
module compare_n #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             A_less_B,
  output logic             A_equal_B,
  output logic             A_greater_B
);

  assign A_less_B    = (a_i <  b_i);
  assign A_equal_B   = (a_i == b_i);
  assign A_greater_B = (a_i >  b_i);

endmodule

// File: rtl/pwm_gen_n.sv
// Multi-channel PWM generator: shared counter, per-channel duty compare, registered outputs.
// Define PWM_GEN_N_SHADOW_EN to transfer duty writes only at period boundaries.
module pwm_gen_n
  import pwm_pkg::*;
#(
  parameter int WIDTH    = PWM_WIDTH_DEF,
  parameter int CHANNELS = PWM_CHANNELS_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic [WIDTH-1:0]             period,
  input  logic                         wr_valid,
  input  logic [ch_bits(CHANNELS)-1:0] wr_ch,
  input  logic [WIDTH-1:0]             wr_duty,
  output logic                         wr_ready,
  output logic [CHANNELS-1:0]          pwm_out,
  output logic [WIDTH-1:0]             cnt,
  output logic                         period_tick
);

  pwm_state_e          state_q, state_d;
  logic [WIDTH-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]    period_act_q, period_act_d;
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic [CHANNELS-1:0] duty_lt;
  logic [WIDTH-1:0]    duty_shd_q [CHANNELS];
  logic [WIDTH-1:0]    duty_shd_d [CHANNELS];
  logic [WIDTH-1:0]    duty_act   [CHANNELS];
  logic                at_wrap;
  logic                unused_wrap_lt, unused_wrap_gt;
  logic [CHANNELS-1:0] unused_duty_eq, unused_duty_gt;

  assign wr_ready    = ~reset;
  assign period_tick = (state_q == RUN) && at_wrap;
  assign pwm_out     = pwm_q;
  assign cnt         = cnt_q;

  compare_n #(.WIDTH(WIDTH)) u_wrap_cmp (
    .a_i        (cnt_q),
    .b_i        (period_act_q),
    .A_less_B   (unused_wrap_lt),
    .A_equal_B  (at_wrap),
    .A_greater_B(unused_wrap_gt)
  );

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    compare_n #(.WIDTH(WIDTH)) u_duty_cmp (
      .a_i        (cnt_q),
      .b_i        (duty_act[g]),
      .A_less_B   (duty_lt[g]),
      .A_equal_B  (unused_duty_eq[g]),
      .A_greater_B(unused_duty_gt[g])
    );
  end

  // Indices at or beyond CHANNELS match no iteration, so such writes are dropped.
  always_comb begin
    duty_shd_d = duty_shd_q;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (wr_valid && wr_ready && (32'(wr_ch) == i)) duty_shd_d[i] = wr_duty;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    period_act_d = period_act_q;
    pwm_d        = '0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (en) begin
          state_d      = RUN;
          period_act_d = period;
        end
      end
      RUN: begin
        if (!en) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          pwm_d = duty_lt;
          if (at_wrap) begin
            cnt_d        = '0;
            period_act_d = period;
          end else begin
            cnt_d = cnt_q + WIDTH'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      period_act_q <= '0;
      pwm_q        <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) duty_shd_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      period_act_q <= period_act_d;
      pwm_q        <= pwm_d;
      duty_shd_q   <= duty_shd_d;
    end
  end

`ifdef PWM_GEN_N_SHADOW_EN
  logic [WIDTH-1:0] duty_act_q [CHANNELS];
  logic             load;

  // Loading from the next-state shadow lets a write on the load edge land directly.
  assign load = en && ((state_q == IDLE) || at_wrap);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < CHANNELS; i++) duty_act_q[i] <= '0;
    end else if (load) begin
      duty_act_q <= duty_shd_d;
    end
  end

  assign duty_act = duty_act_q;
`else
  assign duty_act = duty_shd_q;
`endif

endmodule

// File: doc/pwm_gen_n.md
PWM_GEN_N -- requirements
Module: pwm_gen_n

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter/period/duty bit width (legal 2..16).
REQ-002 SHALL have parameter CHANNELS, default 4, number of independent PWM outputs (legal 1..16).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port en  input  1  run enable; low forces IDLE.
REQ-006 SHALL have port period  input  WIDTH  period value P; cycle length is P+1 clocks; sampled only at load points.
REQ-007 SHALL have port wr_valid  input  1  duty write request.
REQ-008 SHALL have port wr_ch  input  max(1,$clog2(CHANNELS))  target channel index.
REQ-009 SHALL have port wr_duty  input  WIDTH  duty value D for target channel.
REQ-010 SHALL have port wr_ready  output  1  write accept; write occurs when wr_valid && wr_ready.
REQ-011 SHALL have port pwm_out  output  CHANNELS  registered PWM outputs.
REQ-012 SHALL have port cnt  output  WIDTH  current counter value.
REQ-013 SHALL have port period_tick  output  1  one-cycle pulse on the wrap cycle.

Function
REQ-014 SHALL implement FSM states IDLE and RUN; IDLE->RUN when en=1; RUN->IDLE when en=0, evaluated every cycle.
REQ-015 IDLE: cnt held at 0, pwm_out driven 0, period_tick 0.
REQ-016 On the IDLE->RUN edge: cnt=0, period_act<=period, duty_act[i]<=duty_shd[i] for all i.
REQ-017 RUN: cnt increments by 1 each cycle; when cnt==period_act, cnt wraps to 0 next cycle, period_tick=1 that cycle, period_act<=period.
REQ-018 period_act=0 in RUN: cnt stays 0, period_tick high every cycle.
REQ-019 pwm_out[i] SHALL be registered: pwm_out[i](t+1) = (cnt(t) < duty_act[i]) in RUN, so latency is one clock from cnt.
REQ-020 Boundaries: D=0 gives constant low; D>=P+1 gives constant high; no glitch at wrap.
REQ-021 wr_ready SHALL be 1 whenever not in reset, in both states.
REQ-022 An accepted write with wr_ch>=CHANNELS SHALL be ignored without side effects.
REQ-023 An accepted write SHALL update duty_shd[wr_ch] in the same edge.
REQ-024 Comparison width rule: all compares unsigned at WIDTH bits; no overflow when cnt==2^WIDTH-1.

Reset
REQ-025 Reset asserted SHALL immediately force state=IDLE, cnt=0, pwm_out=0, period_tick=0, wr_ready=0, period_act=0, all duty_shd and duty_act=0.
REQ-026 Reset mid-period SHALL discard the in-progress period; after release, RUN restarts from cnt=0 per REQ-016.

Configuration
REQ-027 Macro PWM_GEN_N_SHADOW_EN SHALL select the duty update policy.
REQ-028 With PWM_GEN_N_SHADOW_EN defined: duty_act[i]<=duty_shd[i] only on the wrap cycle and on IDLE->RUN; a write coinciding with the wrap cycle SHALL be included in that transfer (write bypasses to duty_act).
REQ-029 Without PWM_GEN_N_SHADOW_EN: duty_act aliases duty_shd; an accepted write affects pwm_out compare from the next cycle (output change two edges after the write).

Structure
REQ-030 Shared package pwm_pkg SHALL hold the FSM state enum (IDLE, RUN) and default WIDTH/CHANNELS constants.
REQ-031 One sub-module compare_n (parameter WIDTH; outputs A_less_B, A_equal_B, A_greater_B) SHALL be instantiated per channel for cnt<duty_act, plus one for the wrap test cnt==period_act.

Verification
REQ-032 WIDTH=8, CHANNELS=4, P=9, D0=3, en=1 -> pwm_out[0] high 3 of every 10 cycles, period_tick every 10th cycle, cnt 0..9.
REQ-033 D1=0, D2=10, D3=255 with P=9 -> pwm_out[1] always 0, pwm_out[2] and pwm_out[3] always 1 in RUN.
REQ-034 SHADOW_EN: write D0=7 at cnt=4 -> current period keeps 3-cycle high, next period 7-cycle high; write landing on the wrap cycle takes effect immediately in the next period.
REQ-035 No SHADOW_EN: write D0=7 at cnt=2 -> pwm_out[0] stays high through cnt=6 of the same period.
REQ-036 Assert reset at cnt=5, release after 2 cycles -> outputs 0 during reset, wr_ready 0, restart at cnt=0; write with wr_ch=5 (CHANNELS=4) -> no channel changes.
